// File: rtl/core_seq_pkg.sv
// Shared types and constants for the instruction-stage sequencer.
package core_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWrite  = 3'd5,
        StHalted = 3'd6,
        StError  = 3'd7
    } state_t;

    localparam logic [2:0] StageFetch  = 3'd0;
    localparam logic [2:0] StageDecode = 3'd1;
    localparam logic [2:0] StageExec   = 3'd2;
    localparam logic [2:0] StageMem    = 3'd3;
    localparam logic [2:0] StageWrite  = 3'd4;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    function automatic logic [2:0] stage_id(input state_t s);
        case (s)
            StFetch:  return StageFetch;
            StDecode: return StageDecode;
            StExec:   return StageExec;
            StMem:    return StageMem;
            StWrite:  return StageWrite;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic logic is_stage(input state_t s);
        return (s == StFetch) || (s == StDecode) || (s == StExec) || (s == StMem) ||
               (s == StWrite);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage wait counter; flags the wait cycle in which the TIMEOUT-th wait goes unanswered.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Wait cycle k sees a count of k-1, so the last allowed wait cycle sees TIMEOUT-1.
    localparam logic [CntW-1:0] Last = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != Last)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && count_en_i && (cnt_q == Last);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/write sequencer owning the PC and retire counter.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    output logic        fetch_enabled,
    output logic        decode_enabled,
    output logic        exec_enabled,
    output logic        mem_enabled,
    output logic        write_enabled,
    input  logic        fetch_completed,
    input  logic        decode_completed,
    input  logic        exec_completed,
    input  logic        mem_completed,
    input  logic        write_completed,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        writes_to_reg,
    input  logic [31:0] exec_next_pc,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic [31:0] retired,
    output logic        halted,
    output logic        timeout_err,
    output logic [2:0]  err_stage
);

    state_t      state_q, state_d;
    logic [4:0]  en_q, en_d;
    logic [31:0] pc_q, pc_d, next_pc_q, next_pc_d, retired_q, retired_d;
    logic        load_q, load_d, store_q, store_d, wr_q, wr_d;
    logic        timeout_err_q, timeout_err_d;
    logic [2:0]  err_stage_q, err_stage_d;
    logic [4:0]  completed;
    logic        wait_cycle, stage_done, expired, retire;

    assign completed = {write_completed, mem_completed, exec_completed, decode_completed,
                        fetch_completed};

    // The enable pulse marks the first cycle of a stage; completions count only after it.
    assign wait_cycle = is_stage(state_q) && !(|en_q);
    assign stage_done = wait_cycle && completed[stage_id(state_q)];

    always_comb begin
        state_d       = state_q;
        en_d          = '0;
        pc_d          = pc_q;
        next_pc_d     = next_pc_q;
        retired_d     = retired_q;
        load_d        = load_q;
        store_d       = store_q;
        wr_d          = wr_q;
        timeout_err_d = timeout_err_q;
        err_stage_d   = err_stage_q;
        retire        = 1'b0;

        case (state_q)
            StIdle:   if (run) state_d = StFetch;
            StFetch:  if (stage_done) state_d = StDecode;
            StDecode: begin
                if (stage_done) begin
                    load_d  = is_load;
                    store_d = is_store;
                    wr_d    = writes_to_reg;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (stage_done) begin
                    next_pc_d = exec_next_pc;
                    if (load_q || store_q) state_d = StMem;
                    else if (wr_q)         state_d = StWrite;
                    else                   retire  = 1'b1;
                end
            end
            StMem: begin
                if (stage_done) begin
                    if (wr_q) state_d = StWrite;
                    else      retire  = 1'b1;
                end
            end
            StWrite:  if (stage_done) retire = 1'b1;
            StHalted: if (run && !halt_req) state_d = StFetch;
            default:  state_d = state_q;
        endcase

        if (expired && !stage_done) begin
            state_d       = StError;
            timeout_err_d = 1'b1;
            err_stage_d   = stage_id(state_q);
        end

        if (retire) begin
            pc_d      = (state_q == StExec) ? exec_next_pc : next_pc_q;
            retired_d = retired_q + 32'd1;
            if (halt_req)  state_d = StHalted;
            else if (!run) state_d = StIdle;
            else           state_d = StFetch;
        end

        if ((state_d != state_q) && is_stage(state_d)) begin
            en_d[stage_id(state_d)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            en_q          <= '0;
            pc_q          <= RESET_PC;
            next_pc_q     <= RESET_PC;
            retired_q     <= '0;
            load_q        <= 1'b0;
            store_q       <= 1'b0;
            wr_q          <= 1'b0;
            timeout_err_q <= 1'b0;
            err_stage_q   <= '0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
            retired_q     <= retired_d;
            load_q        <= load_d;
            store_q       <= store_d;
            wr_q          <= wr_d;
            timeout_err_q <= timeout_err_d;
            err_stage_q   <= err_stage_d;
        end
    end

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_d != state_q),
        .count_en_i (wait_cycle),
        .expired_o  (expired)
    );

    assign fetch_enabled  = en_q[StageFetch];
    assign decode_enabled = en_q[StageDecode];
    assign exec_enabled   = en_q[StageExec];
    assign mem_enabled    = en_q[StageMem];
    assign write_enabled  = en_q[StageWrite];
    assign pc             = pc_q;
    assign state          = state_q;
    assign retired        = retired_q;
    assign halted         = (state_q == StHalted);
    assign timeout_err    = timeout_err_q;
    assign err_stage      = err_stage_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: table of single instructions plus halt/timeout/reset cases.
module tb_core_sequencer;
    import core_seq_pkg::*;

    localparam logic [31:0] RstPc = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, run, halt_req;
    logic        fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled;
    logic        fetch_completed, decode_completed, exec_completed, mem_completed;
    logic        write_completed;
    logic        is_load, is_store, writes_to_reg;
    logic [31:0] exec_next_pc, pc, retired;
    logic [2:0]  state, err_stage;
    logic        halted, timeout_err;

    logic [4:0]  comp;
    logic [4:0]  en_v;
    int          lat[5];
    int          n_pass = 0;
    int          n_total = 0;
    int          multi_en = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;

    always #5 clk = ~clk;

    assign {write_completed, mem_completed, exec_completed, decode_completed,
            fetch_completed} = comp;
    assign en_v = {write_enabled, mem_enabled, exec_enabled, decode_enabled, fetch_enabled};

    core_sequencer #(
        .RESET_PC (RstPc),
        .TIMEOUT  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .halt_req         (halt_req),
        .fetch_enabled    (fetch_enabled),
        .decode_enabled   (decode_enabled),
        .exec_enabled     (exec_enabled),
        .mem_enabled      (mem_enabled),
        .write_enabled    (write_enabled),
        .fetch_completed  (fetch_completed),
        .decode_completed (decode_completed),
        .exec_completed   (exec_completed),
        .mem_completed    (mem_completed),
        .write_completed  (write_completed),
        .is_load          (is_load),
        .is_store         (is_store),
        .writes_to_reg    (writes_to_reg),
        .exec_next_pc     (exec_next_pc),
        .pc               (pc),
        .state            (state),
        .retired          (retired),
        .halted           (halted),
        .timeout_err      (timeout_err),
        .err_stage        (err_stage)
    );

    // Stage model: answers lat[s] cycles after its enable pulse; lat 0 never answers.
    initial begin
        int cd[5];
        bit pend[5];
        comp = '0;
        for (int s = 0; s < 5; s++) begin
            pend[s] = 1'b0;
            cd[s]   = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 5; s++) begin
                comp[s] = 1'b0;
                if (pend[s]) begin
                    cd[s]--;
                    if (cd[s] == 0) begin
                        comp[s] = 1'b1;
                        pend[s] = 1'b0;
                    end
                end
                if (en_v[s] && lat[s] != 0) begin
                    pend[s] = 1'b1;
                    cd[s]   = lat[s];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if ($countones(en_v) > 1) multi_en++;
    endtask

    task automatic wait_state(input state_t s, input string name);
        int n = 0;
        while (state != s && n < 64) begin
            step();
            n++;
        end
        chk(name, state, s);
    endtask

    task automatic wait_retire(input string name);
        logic [31:0] r0 = retired;
        int n = 0;
        while (retired == r0 && n < 64) begin
            step();
            n++;
        end
        chk(name, retired, r0 + 32'd1);
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic        wr;
        logic [31:0] npc;
        int          mem_lat;
        int          cycles;
        int          n_mem;
        int          n_wr;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc, n_mem, n_wr, bad_pc;
        logic [31:0] pc0, r0;
        bit          done;
        is_load      = v.ld;
        is_store     = v.st;
        writes_to_reg = v.wr;
        exec_next_pc = v.npc;
        lat[3]       = v.mem_lat;
        run = 1'b1;
        step();
        run = 1'b0;
        chk($sformatf("v%0d_fetch_en", idx), fetch_enabled, 1);
        chk($sformatf("v%0d_start_pc", idx), pc, exp_pc);
        pc0 = pc;
        r0 = retired;
        cyc = 1;
        n_mem = 0;
        n_wr = 0;
        bad_pc = 0;
        done = 1'b0;
        while (!done && cyc < 64) begin
            n_mem += int'(mem_enabled);
            n_wr  += int'(write_enabled);
            if (pc != pc0) bad_pc++;
            step();
            if (retired != r0) done = 1'b1;
            else cyc++;
        end
        chk($sformatf("v%0d_cycles", idx), cyc, v.cycles);
        chk($sformatf("v%0d_mem_en", idx), n_mem, v.n_mem);
        chk($sformatf("v%0d_write_en", idx), n_wr, v.n_wr);
        chk($sformatf("v%0d_pc_stable", idx), bad_pc, 0);
        chk($sformatf("v%0d_pc", idx), pc, v.npc);
        chk($sformatf("v%0d_retired", idx), retired, exp_retired + 32'd1);
        chk($sformatf("v%0d_idle", idx), state, StIdle);
        chk($sformatf("v%0d_no_err", idx), timeout_err, 0);
        exp_pc = v.npc;
        exp_retired = exp_retired + 32'd1;
    endtask

    initial begin
        vec_t vecs[8];
        int   cnt;
        // ld st wr npc mem_lat cycles n_mem n_wr
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_1004, 1, 8, 0, 1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_1008, 3, 10, 1, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 1, 6, 0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0104, 1, 10, 1, 1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0108, 1, 8, 1, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_010c, 2, 9, 1, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 8, 15, 1, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 32'hffff_fffc, 1, 8, 0, 1};

        for (int s = 0; s < 5; s++) lat[s] = 1;
        rst = 1'b1;
        run = 1'b0;
        halt_req = 1'b0;
        is_load = 1'b0;
        is_store = 1'b0;
        writes_to_reg = 1'b0;
        exec_next_pc = '0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_state", state, StIdle);
        chk("rst_pc", pc, RstPc);
        chk("rst_retired", retired, 0);
        chk("rst_enables", en_v, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_err_stage", err_stage, 0);
        exp_pc = RstPc;
        exp_retired = '0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Halt raised during EXEC: retire, park in HALTED, resume from same pc.
        is_load = 1'b0;
        is_store = 1'b0;
        writes_to_reg = 1'b1;
        exec_next_pc = 32'h0000_0200;
        run = 1'b1;
        step();
        chk("halt_start_pc", pc, exp_pc);
        wait_state(StExec, "halt_reach_exec");
        halt_req = 1'b1;
        wait_retire("halt_retire");
        chk("halt_state", state, StHalted);
        chk("halt_halted", halted, 1);
        chk("halt_pc", pc, 32'h0000_0200);
        cnt = 0;
        repeat (3) begin
            step();
            cnt += $countones(en_v);
        end
        chk("halt_no_enables", cnt, 0);
        chk("halt_still", halted, 1);
        halt_req = 1'b0;
        step();
        chk("resume_fetch_en", fetch_enabled, 1);
        chk("resume_pc", pc, 32'h0000_0200);
        chk("resume_halted", halted, 0);
        run = 1'b0;
        wait_retire("resume_retire");
        chk("resume_idle", state, StIdle);
        chk("resume_retired", retired, exp_retired + 32'd2);
        exp_pc = 32'h0000_0200;
        exp_retired = exp_retired + 32'd2;

        // Mem never answers: exactly 8 wait cycles, then ERROR.
        is_store = 1'b1;
        writes_to_reg = 1'b0;
        lat[3] = 0;
        run = 1'b1;
        step();
        run = 1'b0;
        cnt = 0;
        while (!mem_enabled && cnt < 32) begin
            step();
            cnt++;
        end
        chk("to_mem_en", mem_enabled, 1);
        repeat (8) step();
        chk("to_wait8_state", state, StMem);
        chk("to_wait8_err", timeout_err, 0);
        step();
        chk("to_state", state, StError);
        chk("to_err", timeout_err, 1);
        chk("to_err_stage", err_stage, 3);
        chk("to_retired", retired, exp_retired);
        run = 1'b1;
        cnt = 0;
        repeat (5) begin
            step();
            cnt += $countones(en_v);
        end
        chk("to_no_enables", cnt, 0);
        chk("to_absorbing", state, StError);
        run = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("to_rst_err", timeout_err, 0);
        chk("to_rst_err_stage", err_stage, 0);
        chk("to_rst_state", state, StIdle);
        exp_pc = RstPc;
        exp_retired = '0;

        run_vec(vecs[0], 8);

        // Reset during DECODE with a late decode completion pending.
        lat[1] = 3;
        exec_next_pc = 32'h0000_0400;
        run = 1'b1;
        step();
        run = 1'b0;
        cnt = 0;
        while (!decode_enabled && cnt < 32) begin
            step();
            cnt++;
        end
        chk("rd_decode_en", decode_enabled, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rd_state", state, StIdle);
        chk("rd_pc", pc, RstPc);
        chk("rd_retired", retired, 0);
        chk("rd_enables", en_v, 0);
        cnt = 0;
        repeat (6) begin
            step();
            cnt += int'(exec_enabled) + int'(state != StIdle);
        end
        chk("rd_no_exec", cnt, 0);

        chk("onehot_enables", multi_en, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
